// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory responder sitting between the core's fetch /
// load-store ports and an 8-bit RAM with one-cycle read latency.
//
// Ports
//   clk, rst, rdy                   clock, sync active-high reset, global enable
//   inst_fe_i, inst_fpc_i           instruction fetch request / word address
//   ex_b_flag_i                     branch flush, aborts an in-flight fetch
//   inst_o, inst_ok_o, inst_pc_o    fetched word, done pulse, its address
//   mem_re_i, mem_we_i              data read / write request
//   mem_addr_i, mem_data_i          data address / store data
//   mem_len_i                       access size in bytes minus one (0/1/3)
//   mem_data_o, mem_ok_o            zero-extended load data, done pulse
//   ram_din, ram_dout, ram_a, ram_wr  RAM byte port
//   io_buffer_full                  UART TX full
//
// Optional feature: define IO_FULL_STALL_EN to hold writes to the UART
// address 0x00030000 in IDLE while io_buffer_full is high.

module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        inst_fe_i,
  input  logic [31:0] inst_fpc_i,
  input  logic        ex_b_flag_i,
  output logic [31:0] inst_o,
  output logic        inst_ok_o,
  output logic [31:0] inst_pc_o,
  input  logic        mem_re_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic [1:0]  mem_len_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ok_o,
  input  logic [7:0]  ram_din,
  output logic [7:0]  ram_dout,
  output logic [31:0] ram_a,
  output logic        ram_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {IDLE, IFETCH, DREAD, DWRITE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_nxt;
  logic [1:0]  len_q;
  logic [31:0] addr_q, wdata_q, rbuf_q, rbuf_nxt, wsh, req_a;
  logic        ram_wr_q;
  logic        io_stall, data_req, accept_d, accept_f, last, abort;

`ifdef IO_FULL_STALL_EN
  assign io_stall = mem_we_i && (mem_addr_i == 32'h0003_0000) && io_buffer_full;
`else
  logic unused_io;
  assign unused_io = io_buffer_full;
  assign io_stall  = 1'b0;
`endif

  // Data requests win over fetches; a stalled UART write blocks fetches too,
  // and a fetch coinciding with a flush is dropped (its address is stale).
  assign data_req = mem_re_i || mem_we_i;
  assign accept_d = (state_q == IDLE) && data_req && !io_stall;
  assign accept_f = (state_q == IDLE) && !data_req && inst_fe_i && !ex_b_flag_i;
  assign req_a    = data_req ? mem_addr_i : inst_fpc_i;

  assign last    = (cnt_q == {1'b0, len_q});
  assign abort   = (state_q == IFETCH) && ex_b_flag_i;
  assign cnt_nxt = cnt_q + 3'd1;
  assign wsh     = wdata_q >> {cnt_nxt[1:0], 3'b000};

  // Byte cnt arrives this cycle; merge it so the final word is complete at EN.
  always_comb begin
    rbuf_nxt = rbuf_q;
    rbuf_nxt[{cnt_q[1:0], 3'b000} +: 8] = ram_din;
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst)      state_q <= IDLE;
    else if (rdy) state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_d)      state_d = mem_we_i ? DWRITE : DREAD;
        else if (accept_f) state_d = IFETCH;
      end
      IFETCH:  if (abort || last) state_d = IDLE;
      default: if (last)          state_d = IDLE;
    endcase
  end

  // outputs: a write strobe must never fire while the pipeline is frozen
  always_comb begin
    ram_wr = ram_wr_q && rdy;
  end

  // datapath / registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      ram_a      <= '0;
      ram_dout   <= '0;
      ram_wr_q   <= 1'b0;
      inst_o     <= '0;
      inst_pc_o  <= '0;
      inst_ok_o  <= 1'b0;
      mem_data_o <= '0;
      mem_ok_o   <= 1'b0;
    end else if (rdy) begin
      inst_ok_o <= 1'b0;
      mem_ok_o  <= 1'b0;
      if (state_q == IDLE) begin
        if (accept_d || accept_f) begin
          addr_q   <= req_a;
          ram_a    <= req_a;
          cnt_q    <= '0;
          rbuf_q   <= '0;   // upper bytes of short loads stay zero
          len_q    <= accept_d ? mem_len_i : 2'd3;
          wdata_q  <= mem_data_i;
          ram_wr_q <= accept_d && mem_we_i;
          if (accept_d && mem_we_i) ram_dout <= mem_data_i[7:0];
        end
      end else begin
        rbuf_q <= rbuf_nxt;
        if (abort || last) begin
          ram_a    <= '0;
          ram_wr_q <= 1'b0;
          if (!abort) begin
            if (state_q == IFETCH) begin
              inst_o    <= rbuf_nxt;
              inst_pc_o <= addr_q;
              inst_ok_o <= 1'b1;
            end else begin
              if (state_q == DREAD) mem_data_o <= rbuf_nxt;
              mem_ok_o <= 1'b1;
            end
          end
        end else begin
          cnt_q <= cnt_nxt;
          ram_a <= addr_q + {29'b0, cnt_nxt};
          if (state_q == DWRITE) ram_dout <= wsh[7:0];
        end
      end
    end
  end

endmodule
